// File: rtl/fp_mult_pkg.sv
// ============================================================================
// Module  : fp_mult_pkg
// Brief   : Shared types and 3:2 carry-save helper for the Booth PP reducer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fp_mult_pkg;

    localparam int PP_W   = 2 * 16;
    localparam int NUM_PP = 6;

    typedef logic [PP_W-1:0] pp_t;
    typedef pp_t pp_vec_t [NUM_PP];

    // Returns {sum, carry<<1}; the carry out of the MSB is dropped (mod 2^PP_W).
    function automatic logic [2*PP_W-1:0] csa32(input pp_t a, input pp_t b, input pp_t c);
        pp_t s;
        pp_t m;
        s = a ^ b ^ c;
        m = (a & b) | (a & c) | (b & c);
        return {s, m << 1};
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_pp_reducer_csa.sv
// ============================================================================
// Module  : pp_csa_3to2
// Brief   : Combinational 3:2 carry-save adder, PP_W bits wide.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pp_csa_3to2
    import fp_mult_pkg::*;
(
    input  pp_t i_a,
    input  pp_t i_b,
    input  pp_t i_c,
    output pp_t o_sum,
    output pp_t o_carry
);

    logic [2*PP_W-1:0] w_res;

    assign w_res   = csa32(i_a, i_b, i_c);
    assign o_sum   = w_res[2*PP_W-1:PP_W];
    assign o_carry = w_res[PP_W-1:0];

endmodule

`default_nettype wire

// File: rtl/booth_pp_reducer.sv
// ============================================================================
// Module  : booth_pp_reducer
// Brief   : 3-stage CSA tree + CPA reducing six radix-8 Booth partial products.
//           Optional accumulator enabled by macro PP_REDUCE_ACC_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_pp_reducer
    import fp_mult_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
`ifdef PP_REDUCE_ACC_EN
    input  logic                     iAccClr,
    output logic [2*BITS+7:0]        oAcc,
`endif
    input  logic                     iValid,
    output logic                     oReady,
    input  logic [NUM_PP*2*BITS-1:0] iPP,
    output logic                     oValid,
    input  logic                     iReady,
    output logic [2*BITS-1:0]        oZ
);

    if (2 * BITS != PP_W) begin : g_width_chk
        $error("BITS does not match the package partial-product width");
    end

    pp_vec_t w_pp;

    for (genvar k = 0; k < NUM_PP; k++) begin : g_unpack
        assign w_pp[k] = iPP[k*PP_W +: PP_W];
    end

    // One global enable stalls every stage together, so bubbles travel with data.
    logic w_adv;
    logic r_s1_vld, r_s2_vld, r_s3_vld;
    pp_t  r_s1_a, r_s1_b, r_s1_c, r_s1_d;
    pp_t  r_s2_sum, r_s2_cry;
    pp_t  r_z;
    pp_t  w_lo_sum, w_lo_cry, w_hi_sum, w_hi_cry;
    pp_t  w_t_sum, w_t_cry, w_s2_sum, w_s2_cry;

    assign w_adv  = ~r_s3_vld | iReady;
    assign oReady = w_adv;
    assign oValid = r_s3_vld;
    assign oZ     = r_z;

    pp_csa_3to2 u_csa_lo (.i_a(w_pp[0]), .i_b(w_pp[1]), .i_c(w_pp[2]), .o_sum(w_lo_sum), .o_carry(w_lo_cry));
    pp_csa_3to2 u_csa_hi (.i_a(w_pp[3]), .i_b(w_pp[4]), .i_c(w_pp[5]), .o_sum(w_hi_sum), .o_carry(w_hi_cry));
    pp_csa_3to2 u_csa_m1 (.i_a(r_s1_a), .i_b(r_s1_b), .i_c(r_s1_c), .o_sum(w_t_sum), .o_carry(w_t_cry));
    pp_csa_3to2 u_csa_m2 (.i_a(w_t_sum), .i_b(w_t_cry), .i_c(r_s1_d), .o_sum(w_s2_sum), .o_carry(w_s2_cry));

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s3_vld <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_c   <= '0;
            r_s1_d   <= '0;
            r_s2_sum <= '0;
            r_s2_cry <= '0;
            r_z      <= '0;
        end else if (w_adv) begin
            r_s1_vld <= iValid;
            r_s1_a   <= w_lo_sum;
            r_s1_b   <= w_lo_cry;
            r_s1_c   <= w_hi_sum;
            r_s1_d   <= w_hi_cry;
            r_s2_vld <= r_s1_vld;
            r_s2_sum <= w_s2_sum;
            r_s2_cry <= w_s2_cry;
            r_s3_vld <= r_s2_vld;
            // The visible result only moves when a real operation arrives.
            if (r_s2_vld) begin
                r_z <= r_s2_sum + r_s2_cry;
            end
        end
    end

`ifdef PP_REDUCE_ACC_EN
    logic [PP_W+7:0] r_acc;
    logic [PP_W+7:0] w_acc_base;

    assign w_acc_base = iAccClr ? '0 : r_acc;
    assign oAcc       = r_acc;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_acc <= '0;
        end else if (r_s3_vld && iReady) begin
            r_acc <= w_acc_base + {{8{r_z[PP_W-1]}}, r_z};
        end else if (iAccClr) begin
            r_acc <= '0;
        end
    end
`else
    // Accumulator not present in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_booth_pp_reducer.sv
// ============================================================================
// Module  : tb_booth_pp_reducer
// Brief   : Self-checking bench for booth_pp_reducer (vector table + scoreboard).
//           Exercises the accumulator when PP_REDUCE_ACC_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_booth_pp_reducer;

    typedef struct {
        logic [191:0] pp;
        logic [31:0]  exp;
    } vec_t;

    logic         r_clk = 1'b0;
    logic         r_rst_n = 1'b0;
    logic         r_valid = 1'b0;
    logic         r_iready = 1'b0;
    logic [191:0] r_pp = '0;
    logic         w_oready;
    logic         w_ovalid;
    logic [31:0]  w_oz;
`ifdef PP_REDUCE_ACC_EN
    logic         r_accclr = 1'b0;
    logic [39:0]  w_acc;
    logic [39:0]  m_acc = '0;
`endif

    logic [31:0] sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_out = 0;
    vec_t        tbl[8];

    always #5 r_clk = ~r_clk;

    booth_pp_reducer #(.BITS(16)) dut (
        .iClk   (r_clk),
        .iRst_n (r_rst_n),
`ifdef PP_REDUCE_ACC_EN
        .iAccClr(r_accclr),
        .oAcc   (w_acc),
`endif
        .iValid (r_valid),
        .oReady (w_oready),
        .iPP    (r_pp),
        .oValid (w_ovalid),
        .iReady (r_iready),
        .oZ     (w_oz)
    );

    function automatic logic [191:0] pack6(input logic [31:0] a0, a1, a2, a3, a4, a5);
        return {a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle, sample #4 later (before the next rising edge).
    task automatic cycle(input logic v, input logic [191:0] pp, input logic [31:0] exp,
                         input logic rdy, output logic ov, output logic acc);
        logic [31:0] popped;
        logic        out_hs;
        @(negedge r_clk);
        r_valid  = v;
        r_pp     = pp;
        r_iready = rdy;
        #4;
        ov     = w_ovalid;
        out_hs = w_ovalid && r_iready;
        popped = '0;
        if (w_ovalid && !r_iready) begin
            check("stall_oready", {63'd0, w_oready}, 64'd0);
            if (sb_q.size() != 0) check("stall_hold_oz", {32'd0, w_oz}, {32'd0, sb_q[0]});
        end
        if (out_hs) begin
            n_out++;
            if (sb_q.size() == 0) begin
                check("unexpected_output", {63'd0, w_ovalid}, 64'd0);
            end else begin
                popped = sb_q.pop_front();
                check("oz", {32'd0, w_oz}, {32'd0, popped});
            end
        end
`ifdef PP_REDUCE_ACC_EN
        check("oacc", {24'd0, w_acc}, {24'd0, m_acc});
        if (out_hs) m_acc = (r_accclr ? 40'd0 : m_acc) + {{8{popped[31]}}, popped};
        else if (r_accclr) m_acc = '0;
`endif
        acc = r_valid && w_oready;
        if (acc) sb_q.push_back(exp);
    endtask

    task automatic drain();
        logic ov, acc;
        int   budget;
        budget = 40;
        while (sb_q.size() != 0 && budget > 0) begin
            cycle(1'b0, '0, '0, 1'b1, ov, acc);
            budget--;
        end
        if (sb_q.size() != 0) check("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ov, acc;
        logic exp_ov[5];
        int   nxt, outs_before;

        tbl[0] = '{pack6(32'h0000_000F, 0, 0, 0, 0, 0), 32'h0000_000F};
        tbl[1] = '{pack6(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                         32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFA};
        tbl[2] = '{pack6(32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h20), 32'h0000_003F};
        tbl[3] = '{pack6(32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0), 32'h0000_0000};
        tbl[4] = '{pack6(32'h1234_5678, 32'h1111_1111, 0, 0, 0, 32'h1), 32'h2345_678A};
        tbl[5] = '{pack6(32'hAAAA_AAAA, 32'h5555_5555, 32'h1, 0, 0, 0), 32'h0000_0000};
        tbl[6] = '{pack6(32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 0, 0, 0), 32'h2D2D_2D2D};
        tbl[7] = '{pack6(32'h7, 32'h7, 32'h7, 32'h7, 32'h7, 32'h7), 32'h0000_002A};

        // Reset state
        #2;
        check("rst_ovalid", {63'd0, w_ovalid}, 64'd0);
        check("rst_oz", {32'd0, w_oz}, 64'd0);
        @(negedge r_clk);
        r_rst_n = 1'b1;
        #1;
        check("post_rst_oready", {63'd0, w_oready}, 64'd1);
`ifdef PP_REDUCE_ACC_EN
        check("rst_oacc", {24'd0, w_acc}, 64'd0);
`endif

        // Single op: oValid pattern across five sample points
        exp_ov = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 5; c++) begin
            cycle(c == 0, tbl[0].pp, tbl[0].exp, 1'b1, ov, acc);
            check($sformatf("single_ovalid_c%0d", c), {63'd0, ov}, {63'd0, exp_ov[c]});
        end

        // Table vectors back to back
        for (int i = 0; i < 8; i++) cycle(1'b1, tbl[i].pp, tbl[i].exp, 1'b1, ov, acc);
        drain();

        // Streaming: ten ops, results on consecutive cycles
        for (int c = 0; c < 13; c++) begin
            cycle(c < 10, pack6(32'(c), 0, 0, 0, 0, 0), 32'(c), 1'b1, ov, acc);
            check("stream_oready", {63'd0, w_oready}, 64'd1);
            if (c >= 3) check($sformatf("stream_ovalid_c%0d", c), {63'd0, ov}, 64'd1);
        end
        drain();

        // Backpressure: four ops offered while the consumer stalls for five cycles
        nxt = 0;
        for (int c = 0; c < 5; c++) begin
            cycle(nxt < 4, pack6(32'(nxt), 0, 0, 0, 0, 0), 32'(nxt), 1'b0, ov, acc);
            if (acc) nxt++;
        end
        check("bp_accepted", 64'(nxt), 64'd3);
        check("bp_ovalid", {63'd0, w_ovalid}, 64'd1);
        check("bp_oready", {63'd0, w_oready}, 64'd0);
        check("bp_oz", {32'd0, w_oz}, 64'd0);
        for (int c = 0; c < 10 && nxt < 4; c++) begin
            cycle(1'b1, pack6(32'(nxt), 0, 0, 0, 0, 0), 32'(nxt), 1'b1, ov, acc);
            if (acc) nxt++;
        end
        check("bp_all_issued", 64'(nxt), 64'd4);
        drain();

        // Reset with three operations in flight
        for (int c = 0; c < 3; c++) cycle(1'b1, pack6(32'(100 + c), 0, 0, 0, 0, 0), 32'(100 + c), 1'b1, ov, acc);
        @(negedge r_clk);
        r_valid = 1'b0;
        #1;
        check("mid_inflight_ovalid", {63'd0, w_ovalid}, 64'd1);
        r_rst_n = 1'b0;
        #1;
        check("mid_rst_ovalid", {63'd0, w_ovalid}, 64'd0);
        check("mid_rst_oz", {32'd0, w_oz}, 64'd0);
        sb_q.delete();
`ifdef PP_REDUCE_ACC_EN
        m_acc = '0;
`endif
        @(negedge r_clk);
        r_rst_n = 1'b1;
        outs_before = n_out;
        for (int c = 0; c < 6; c++) begin
            cycle(1'b0, '0, '0, 1'b1, ov, acc);
            check("post_rst_no_ovalid", {63'd0, ov}, 64'd0);
        end
        check("post_rst_no_outputs", 64'(n_out - outs_before), 64'd0);

`ifdef PP_REDUCE_ACC_EN
        // Accumulator: 5, 7, then a cleared accumulate of 2
        r_accclr = 1'b1;
        cycle(1'b0, '0, '0, 1'b1, ov, acc);
        r_accclr = 1'b0;
        cycle(1'b1, pack6(32'd5, 0, 0, 0, 0, 0), 32'd5, 1'b1, ov, acc);
        drain();
        cycle(1'b0, '0, '0, 1'b1, ov, acc);
        check("acc_5", {24'd0, w_acc}, 64'd5);
        cycle(1'b1, pack6(32'd7, 0, 0, 0, 0, 0), 32'd7, 1'b1, ov, acc);
        drain();
        cycle(1'b0, '0, '0, 1'b1, ov, acc);
        check("acc_12", {24'd0, w_acc}, 64'd12);
        r_accclr = 1'b1;
        cycle(1'b1, pack6(32'd2, 0, 0, 0, 0, 0), 32'd2, 1'b1, ov, acc);
        drain();
        r_accclr = 1'b0;
        cycle(1'b0, '0, '0, 1'b1, ov, acc);
        check("acc_2", {24'd0, w_acc}, 64'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
